// File: rtl/core_run_pkg.sv
// Shared definitions for the core run controller.
//   run_state_t         - controller FSM states
//   TOHOST_ADDR_DEFAULT - default completion mailbox address
//   PASS_CODE           - tohost value that signals a passing run
package core_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_00FC;
  localparam int          PASS_CODE           = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that stops at all-ones
// instead of wrapping.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - synchronous clear (wins over en)
//   en       - count enable
//   count    - current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: holds the core in reset
// for RESET_CYCLES after start, counts RUN cycles, and ends the run on a
// write to the tohost mailbox or on the cycle limit.
//   clk, rst            - clock, asynchronous active-high reset
//   start, abort        - launch (IDLE/DONE) / cancel (RESET/RUN) a run
//   mem_we/addr/wdata   - monitored core data-memory write bus
//   core_rst_n          - active-low reset to the core
//   running, done       - run status
//   pass, timeout       - outcome flags
//   result              - latched tohost value (fail code in result[DW-1:1])
//   cycle_count         - RUN cycles elapsed
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int            DW             = 32,
  parameter int            AW             = 32,
  parameter int            RESET_CYCLES   = 3,
  parameter int            TIMEOUT_CYCLES = 1024,
  parameter int            CNT_W          = 32,
  parameter logic [AW-1:0] TOHOST_ADDR    = AW'(TOHOST_ADDR_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mem_we,
  input  logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_wdata,
  output logic             core_rst_n,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [DW-1:0]    result,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int               RW       = $clog2(RESET_CYCLES) + 1;
  localparam logic [RW-1:0]    RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  generate
    if (RESET_CYCLES < 1) begin : g_chk_rst
      $error("core_run_ctrl: RESET_CYCLES must be >= 1");
    end
    if ((CNT_W < 63) && ((64'(TIMEOUT_CYCLES) >> CNT_W) != 64'd0)) begin : g_chk_to
      $error("core_run_ctrl: TIMEOUT_CYCLES must be < 2**CNT_W");
    end
  endgenerate

  run_state_t    state, state_nx;
  logic          core_rst_n_nx, running_nx, done_nx, pass_nx, timeout_nx;
  logic [DW-1:0] result_nx;
  logic          rcnt_clr, rcnt_en, ccnt_clr, ccnt_en;
  logic [RW-1:0] rcnt;
  logic          tohost_hit, limit_hit;

  sat_counter #(.W(RW)) u_rst_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (rcnt_clr),
    .en    (rcnt_en),
    .count (rcnt)
  );

  // Counter saturation is what keeps cycle_count from wrapping when the
  // timeout is disabled; with a limit it never gets that far.
  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (ccnt_clr),
    .en    (ccnt_en),
    .count (cycle_count)
  );

  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
  assign limit_hit  = TO_EN && (cycle_count == TO_LAST);

  // Outputs are registered: their next values are decided here alongside
  // the next state, so core_rst_n/running change on the same edge as state.
  always_comb begin
    state_nx      = state;
    core_rst_n_nx = 1'b0;
    running_nx    = 1'b0;
    done_nx       = done;
    pass_nx       = pass;
    timeout_nx    = timeout;
    result_nx     = result;
    rcnt_clr      = 1'b0;
    rcnt_en       = 1'b0;
    ccnt_clr      = 1'b0;
    ccnt_en       = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx   = RESET;
          rcnt_clr   = 1'b1;
          done_nx    = 1'b0;
          pass_nx    = 1'b0;
          timeout_nx = 1'b0;
          result_nx  = '0;
        end
      end
      RESET: begin
        rcnt_en = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else if (rcnt == RST_LAST) begin
          state_nx      = RUN;
          ccnt_clr      = 1'b1;
          core_rst_n_nx = 1'b1;
          running_nx    = 1'b1;
        end
      end
      RUN: begin
        // Every RUN edge counts, including the one that leaves RUN.
        ccnt_en = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else if (tohost_hit) begin
          state_nx   = DONE;
          done_nx    = 1'b1;
          result_nx  = mem_wdata;
          pass_nx    = (mem_wdata == DW'(PASS_CODE));
          timeout_nx = 1'b0;
        end else if (limit_hit) begin
          state_nx   = DONE;
          done_nx    = 1'b1;
          timeout_nx = 1'b1;
          pass_nx    = 1'b0;
          result_nx  = '0;
        end else begin
          core_rst_n_nx = 1'b1;
          running_nx    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      core_rst_n <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      result     <= '0;
    end else begin
      state      <= state_nx;
      core_rst_n <= core_rst_n_nx;
      running    <= running_nx;
      done       <= done_nx;
      pass       <= pass_nx;
      timeout    <= timeout_nx;
      result     <= result_nx;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl. Two instances share all inputs:
// dut_a (TIMEOUT_CYCLES=1024) and dut_b (TIMEOUT_CYCLES=8), both with
// RESET_CYCLES=3. Expected output snapshots are queued per cycle and
// compared after the following clock edge.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;

  logic        a_core_rst_n, a_running, a_done, a_pass, a_timeout;
  logic [31:0] a_result, a_cycle_count;
  logic        b_core_rst_n, b_running, b_done, b_pass, b_timeout;
  logic [31:0] b_result, b_cycle_count;

  always #5 clk = ~clk;

  core_run_ctrl #(.DW(32), .AW(32), .RESET_CYCLES(3), .TIMEOUT_CYCLES(1024),
                  .CNT_W(32), .TOHOST_ADDR(32'h0000_00FC)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(a_core_rst_n), .running(a_running), .done(a_done),
    .pass(a_pass), .timeout(a_timeout), .result(a_result),
    .cycle_count(a_cycle_count)
  );

  core_run_ctrl #(.DW(32), .AW(32), .RESET_CYCLES(3), .TIMEOUT_CYCLES(8),
                  .CNT_W(32), .TOHOST_ADDR(32'h0000_00FC)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(b_core_rst_n), .running(b_running), .done(b_done),
    .pass(b_pass), .timeout(b_timeout), .result(b_result),
    .cycle_count(b_cycle_count)
  );

  typedef struct {
    string       tag;
    bit          is_b;
    logic [68:0] exp;
  } exp_t;

  exp_t sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Snapshot layout: {core_rst_n, running, done, pass, timeout, result, cycle_count}
  function automatic logic [68:0] mk(input bit crn, input bit run, input bit dn,
                                     input bit ps, input bit to,
                                     input logic [31:0] res, input logic [31:0] cnt);
    return {crn, run, dn, ps, to, res, cnt};
  endfunction

  function automatic logic [68:0] snap(input bit is_b);
    if (is_b)
      return {b_core_rst_n, b_running, b_done, b_pass, b_timeout, b_result, b_cycle_count};
    return {a_core_rst_n, a_running, a_done, a_pass, a_timeout, a_result, a_cycle_count};
  endfunction

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [68:0] ea, input logic [68:0] eb);
    exp_t e;
    e.tag = {tag, "_a"}; e.is_b = 1'b0; e.exp = ea; sb.push_back(e);
    e.tag = {tag, "_b"}; e.is_b = 1'b1; e.exp = eb; sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, snap(e.is_b), e.exp);
    end
  endtask

  // Queue expectations, take one clock edge, compare 1 time unit after it.
  task automatic cyc(input string tag, input logic [68:0] ea, input logic [68:0] eb);
    push(tag, ea, eb);
    @(posedge clk);
    #1;
    drain();
  endtask

  // start pulse plus three RESET cycles; cycle_count holds until RUN.
  task automatic launch(input string tag, input logic [31:0] ca, input logic [31:0] cb);
    start = 1'b1;
    cyc({tag, "_rst0"}, mk(0,0,0,0,0,0,ca), mk(0,0,0,0,0,0,cb));
    start = 1'b0;
    cyc({tag, "_rst1"}, mk(0,0,0,0,0,0,ca), mk(0,0,0,0,0,0,cb));
    cyc({tag, "_rst2"}, mk(0,0,0,0,0,0,ca), mk(0,0,0,0,0,0,cb));
    cyc({tag, "_run0"}, mk(1,1,0,0,0,0,0), mk(1,1,0,0,0,0,0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [68:0] r0, tb8, ea, eb;
    r0  = mk(0,0,0,0,0,0,0);
    tb8 = mk(0,0,1,0,1,0,8);

    // Reset state while rst is held.
    #2;
    push("por", r0, r0);
    drain();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("idle", r0, r0);

    // Run 1: reset sequence, count, ignored 0xF8 write, pass at cycle 20;
    // dut_b times out after 8 RUN cycles.
    launch("s1", 0, 0);
    for (int n = 1; n <= 19; n++) begin
      if (n == 10) begin
        mem_we = 1'b1; mem_addr = 32'h0000_00F8; mem_wdata = 32'h1;
      end
      ea = mk(1,1,0,0,0,0,n);
      eb = (n < 8) ? mk(1,1,0,0,0,0,n) : tb8;
      cyc($sformatf("s1_cnt%0d", n), ea, eb);
      mem_we = 1'b0;
    end
    mem_we = 1'b1; mem_addr = 32'h0000_00FC; mem_wdata = 32'h1;
    cyc("s1_pass", mk(0,0,1,1,0,1,20), tb8);
    mem_we = 1'b0;
    cyc("s1_hold", mk(0,0,1,1,0,1,20), tb8);

    // Run 2: start in DONE clears flags/result; tohost 7 is a fail, code 3.
    launch("s2", 20, 8);
    for (int n = 1; n <= 4; n++)
      cyc($sformatf("s2_cnt%0d", n), mk(1,1,0,0,0,0,n), mk(1,1,0,0,0,0,n));
    mem_we = 1'b1; mem_addr = 32'h0000_00FC; mem_wdata = 32'h7;
    cyc("s2_fail", mk(0,0,1,0,0,7,5), mk(0,0,1,0,0,7,5));
    mem_we = 1'b0;
    chk("s2_failcode", {38'b0, a_result[31:1]}, 69'd3);

    // Run 3: tohost write on the timeout cycle of dut_b wins.
    launch("s3", 5, 5);
    for (int n = 1; n <= 7; n++)
      cyc($sformatf("s3_cnt%0d", n), mk(1,1,0,0,0,0,n), mk(1,1,0,0,0,0,n));
    mem_we = 1'b1; mem_addr = 32'h0000_00FC; mem_wdata = 32'h1;
    cyc("s3_tie", mk(0,0,1,1,0,1,8), mk(0,0,1,1,0,1,8));
    mem_we = 1'b0;

    // Run 4: start ignored in RUN, abort at cycle 5, abort ignored in IDLE,
    // abort during RESET, then a clean relaunch.
    launch("s4", 8, 8);
    for (int n = 1; n <= 4; n++) begin
      if (n == 2) start = 1'b1;
      cyc($sformatf("s4_cnt%0d", n), mk(1,1,0,0,0,0,n), mk(1,1,0,0,0,0,n));
      start = 1'b0;
    end
    abort = 1'b1;
    cyc("s4_abort", mk(0,0,0,0,0,0,5), mk(0,0,0,0,0,0,5));
    cyc("s4_idle_abort", mk(0,0,0,0,0,0,5), mk(0,0,0,0,0,0,5));
    abort = 1'b0;
    start = 1'b1;
    cyc("s4_rst_a", mk(0,0,0,0,0,0,5), mk(0,0,0,0,0,0,5));
    start = 1'b0;
    abort = 1'b1;
    cyc("s4_rst_abort", mk(0,0,0,0,0,0,5), mk(0,0,0,0,0,0,5));
    abort = 1'b0;
    cyc("s4_idle2", mk(0,0,0,0,0,0,5), mk(0,0,0,0,0,0,5));
    launch("s4b", 5, 5);
    for (int n = 1; n <= 3; n++)
      cyc($sformatf("s4b_cnt%0d", n), mk(1,1,0,0,0,0,n), mk(1,1,0,0,0,0,n));

    // Asynchronous reset between edges, mid-RUN.
    #2;
    rst = 1'b1;
    #1;
    push("async_rst", r0, r0);
    drain();
    rst = 1'b0;
    cyc("after_rst", r0, r0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Synthesizable run controller for the single-cycle RISC-V core. It sequences the core's reset and counts execution cycles. It watches data-memory writes for a "tohost" completion word and flags pass, fail or timeout. It sits beside `Single_Cycle_Top`, driving its active-low reset, and replaces hand-timed reset/finish sequences with a parametrised, restartable, self-reporting controller usable in simulation and on FPGA.

## Interface
Parameters:
- `DW`, 32, data width of the monitored memory write bus.
- `AW`, 32, address width of the monitored memory write bus.
- `RESET_CYCLES`, 3, number of cycles the core is held in reset after `start`; must be ≥ 1.
- `TIMEOUT_CYCLES`, 1024, run-cycle limit; 0 disables the timeout.
- `CNT_W`, 32, width of `cycle_count`; must satisfy `TIMEOUT_CYCLES < 2**CNT_W`.
- `TOHOST_ADDR`, 32'h0000_00FC, completion mailbox address.

Ports:
- `clk`, in, 1, single clock; all logic is rising-edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `start`, in, 1, launch a run; sampled only in IDLE or DONE.
- `abort`, in, 1, cancel a run; sampled only in RESET or RUN.
- `mem_we`, in, 1, core data-memory write enable.
- `mem_addr`, in, AW, core data-memory write address.
- `mem_wdata`, in, DW, core data-memory write data.
- `core_rst_n`, out, 1, active-low reset to the core.
- `running`, out, 1, high while in RUN.
- `done`, out, 1, run finished (tohost write or timeout).
- `pass`, out, 1, tohost value == 1.
- `timeout`, out, 1, run ended by the cycle limit.
- `result`, out, DW, latched tohost value.
- `cycle_count`, out, CNT_W, number of RUN cycles elapsed.

## Operation
- FSM states: IDLE, RESET, RUN, DONE. All outputs are registered.
- Reset values (async on `rst`): state=IDLE, `core_rst_n`=0, `running`=0, `done`=0, `pass`=0, `timeout`=0, `result`=0, `cycle_count`=0, internal reset counter=0.
- IDLE: core is held in reset. `start`=1 → RESET, reset counter cleared.
- RESET: `core_rst_n`=0. The reset counter increments each cycle. When it equals RESET_CYCLES-1 → RUN, with `cycle_count` cleared. `abort`=1 → IDLE, and abort has priority.
- RUN: `core_rst_n`=1, `running`=1, and `cycle_count` increments by 1 per cycle. Exit conditions, in priority order:
  - `abort`=1 → IDLE; no `done`; `cycle_count` is retained.
  - `mem_we`=1 and `mem_addr`==TOHOST_ADDR → DONE. `result`←`mem_wdata`; `pass`←(`mem_wdata`==1).
  - `TIMEOUT_CYCLES`≠0 and `cycle_count`==TIMEOUT_CYCLES-1 → DONE, `timeout`=1, `pass`=0, `result`=0.
- A tohost write on the same cycle as the timeout condition wins: `timeout`=0 and `result` is latched.
- Writes to addresses other than TOHOST_ADDR are ignored.
- DONE: `core_rst_n`=0, `running`=0. `done`, `pass`, `timeout`, `result` and `cycle_count` hold. `start`=1 → RESET and clears `done`/`pass`/`timeout`/`result` on that edge.
- `start` is ignored in RESET and RUN. `abort` is ignored in IDLE and DONE.
- With `TIMEOUT_CYCLES`=0, `cycle_count` saturates at 2**CNT_W-1 and never wraps.
- Fail code convention: when `pass`=0 and `timeout`=0, the failing test number is `result[DW-1:1]`.

## Timing
- `start` high at edge k → state RESET after k. `core_rst_n` stays 0 through edge k+RESET_CYCLES-1, then rises after edge k+RESET_CYCLES (state RUN). The core therefore sees exactly RESET_CYCLES low cycles after start acceptance.
- `cycle_count` equals the number of RUN edges taken; it reads n after n cycles in RUN.
- A tohost write sampled at edge m → `done`, `pass` and `result` are valid and `core_rst_n`=0 after edge m (1-cycle latency). The core executes no further cycles.
- Timeout: `done`=1 after exactly TIMEOUT_CYCLES RUN cycles.
- Asserting `rst` at any time, including mid-RUN, forces the reset values immediately with no clock needed. Release takes effect at the next edge.

## Structure
- Package `core_run_pkg` holds:
  - the state enum (IDLE/RESET/RUN/DONE);
  - `TOHOST_ADDR_DEFAULT` = 32'h0000_00FC;
  - `PASS_CODE` = 1.
- Sub-module `sat_counter` (parametrised width; clear, enable and saturate) is used for both the reset counter and `cycle_count`.
- Elaboration-time checks cover `RESET_CYCLES` ≥ 1 and `TIMEOUT_CYCLES` < 2**CNT_W.

## Test plan
- `RESET_CYCLES`=3; pulse `start` → `core_rst_n` is low for exactly 3 cycles, then high with `running`=1 and `cycle_count` counting 1, 2, 3…
- In RUN, write 32'h1 to 0xFC at cycle 20 → next cycle `done`=1, `pass`=1, `result`=1, `cycle_count`=20, `core_rst_n`=0.
- Write 32'h7 to 0xFC → `pass`=0, `timeout`=0, `result`=7, fail code 3. A write of 32'h1 to 0xF8 beforehand has no effect.
- `TIMEOUT_CYCLES`=8, no tohost write → `done`=1 and `timeout`=1 after 8 RUN cycles. With a tohost write of 1 on cycle 8 → `pass`=1 and `timeout`=0.
- `abort` at RUN cycle 5 → IDLE, `done`=0, `core_rst_n`=0. Then `start` → full reset sequence again with cleared flags.
- Assert `rst` mid-RUN between clock edges → all outputs take their reset values immediately. `start` in DONE restarts and clears the previous `result`.
